ifetch_unit: RTL
================

# ifetch_unit

Instruction-fetch stage that consumes the PC unit's `cur_pc`, reads the addressed word from instruction memory over a req/ack handshake, and presents the instruction downstream with a valid/ready handshake. It is the consumer end of the PC-unit interface. It pulses `pc_advance` once per successful fetch so the PC unit steps exactly once per instruction. It sits between `pc_unit` and the decode stage of the single-cycle prototype, and handles variable memory latency, redirect flushes, misaligned PCs and bus timeouts.

## Interface
- `TIMEOUT`, default 16: number of cycles in REQ without `mem_ack` before a bus-timeout fault (range 2..255).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cur_pc`  in  32  current PC from `pc_unit`.
- `pc_advance`  out  1  one-cycle pulse; the PC unit steps to the next PC on the following edge.
- `flush`  in  1  redirect; discard in-flight/held fetch.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  32  word address (byte PC); stable while `mem_req`=1.
- `mem_ack`  in  1  read data valid this cycle.
- `mem_rdata`  in  32  read data.
- `insn_valid`  out  1  instruction available.
- `insn`  out  32  instruction word.
- `insn_pc`  out  32  PC of `insn`.
- `insn_fault`  out  1  qualifies `insn_valid`: misaligned PC or bus timeout.
- `insn_ready`  in  1  downstream accepts when `insn_valid`=1.

## Operation
- States: IDLE, REQ, HOLD, DROP.
- Reset: outputs are 0 immediately, without waiting for `clk`. This covers `pc_advance`, `mem_req`, `mem_addr`, `insn_valid`, `insn`, `insn_pc` and `insn_fault`. State = IDLE, timeout counter = 0.
- IDLE, `flush`=1: stay IDLE.
- IDLE, `cur_pc[1:0]`≠0: go to HOLD with `insn_valid`=1, `insn_fault`=1, `insn`=0, `insn_pc`=`cur_pc`. No bus request and no `pc_advance`.
- IDLE, otherwise: `mem_addr`<=`cur_pc`, `mem_req`<=1, counter<=0, go to REQ.
- REQ, `mem_ack`=1 and `flush`=0:
  - `insn`<=`mem_rdata`, `insn_pc`<=`mem_addr`, `insn_valid`<=1, `insn_fault`<=0.
  - `pc_advance`<=1 for exactly one cycle, `mem_req`<=0, go to HOLD.
- REQ, `mem_ack`=1 and `flush`=1: data discarded, `mem_req`<=0, no `pc_advance`, go to IDLE.
- REQ, `flush`=1 without ack: a bus transaction cannot be aborted. Keep `mem_req`=1 and go to DROP.
- REQ, no ack: counter increments. When counter = `TIMEOUT`-1 and still no ack:
  - `mem_req`<=0; go to HOLD with `insn_valid`=1, `insn_fault`=1, `insn`=0, `insn_pc`=`mem_addr`.
  - No `pc_advance`.
- DROP: wait for `mem_ack`, or for the timeout under the same counter rule. On either, `mem_req`<=0 and go to IDLE with nothing presented. Further `flush` in DROP is ignored.
- HOLD: outputs held stable while `insn_ready`=0.
  - `insn_valid`&`insn_ready`: `insn_valid`<=0, go to IDLE.
  - `flush`=1, with or without ready: `insn_valid`<=0, `insn_fault`<=0, go to IDLE.
- A fault is never retried automatically. Recovery is by `flush` with a new PC, or by `reset`.
- Counter width: 8 bits, saturating; it never wraps.

## Timing
- Minimum fetch: IDLE edge (req rises), ack in the same cycle as the first `mem_req`=1, capture edge (`insn_valid` rises), accept edge.
- Result: 3 cycles per instruction with zero-wait memory and `insn_ready` held at 1.
- `pc_advance` is high during the same cycle as the first `insn_valid`=1. `cur_pc` updates on the next edge, before IDLE samples it.
- `mem_ack` is sampled only while `mem_req`=1. A stray ack in IDLE or HOLD is ignored.
- `mem_addr` holds its last value after `mem_req` falls until the next request.
- Reset asserted mid-REQ: `mem_req` drops asynchronously; no `pc_advance` and no `insn_valid` occur.

## Test plan
- Zero-wait fetch:
  - Stimulus: `cur_pc`=0x0, `mem_ack` in the first request cycle, `mem_rdata`=0x00A00093, `insn_ready`=1.
  - Response: `insn`=0x00A00093, `insn_pc`=0, `pc_advance` pulses once, next request has `mem_addr`=0x4, 3 cycles per instruction.
- Wait states and backpressure:
  - Stimulus: ack after 3 wait cycles, `insn_ready` low for 4 cycles.
  - Response: `mem_addr` stable throughout, `insn`/`insn_pc` stable while held, exactly one `pc_advance`.
- Flush:
  - Flush in REQ without ack: `mem_req` stays high until ack, data dropped, no `insn_valid`, no `pc_advance`.
  - Flush coinciding with ack: same result.
  - Flush in HOLD: `insn_valid` falls on the next edge.
- Misaligned PC:
  - Stimulus: `cur_pc`=0x6.
  - Response: `mem_req` never rises; `insn_valid`=1, `insn_fault`=1, `insn`=0, `insn_pc`=0x6; no `pc_advance`.
- Timeout:
  - Stimulus: `TIMEOUT`=4, never ack.
  - Response: `mem_req` falls after 4 REQ cycles, faulted instruction presented, `pc_advance` stays 0.
- Reset mid-fetch:
  - Stimulus: assert `reset` between edges during REQ.
  - Response: `mem_req`=0 and all outputs 0 before the next edge; fetching resumes from the new `cur_pc` after release.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetches the word at cur_pc over a req/ack bus and presents it downstream via valid/ready.
module ifetch_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cur_pc,
    output logic        pc_advance,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        insn_valid,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_fault,
    input  logic        insn_ready
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t state, state_n;
    logic [7:0] cnt, cnt_n, cnt_inc;
    logic req_n, valid_n, fault_n, adv_n, to;
    logic [31:0] addr_n, insn_n, ipc_n;
    assign to = cnt == LAST;
    assign cnt_inc = cnt == 8'hff ? cnt : cnt + 8'd1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            insn_valid <= 1'b0;
            insn       <= '0;
            insn_pc    <= '0;
            insn_fault <= 1'b0;
            pc_advance <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            mem_req    <= req_n;
            mem_addr   <= addr_n;
            insn_valid <= valid_n;
            insn       <= insn_n;
            insn_pc    <= ipc_n;
            insn_fault <= fault_n;
            pc_advance <= adv_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = mem_req;
        addr_n  = mem_addr;
        valid_n = insn_valid;
        insn_n  = insn;
        ipc_n   = insn_pc;
        fault_n = insn_fault;
        adv_n   = 1'b0;
        case (state)
            IDLE: if (!flush) begin
                if (cur_pc[1:0] != 2'b00) begin
                    state_n = HOLD;
                    valid_n = 1'b1;
                    fault_n = 1'b1;
                    insn_n  = '0;
                    ipc_n   = cur_pc;
                end else begin
                    state_n = REQ;
                    addr_n  = cur_pc;
                    req_n   = 1'b1;
                    cnt_n   = '0;
                end
            end
            REQ: if (mem_ack) begin
                req_n   = 1'b0;
                state_n = flush ? IDLE : HOLD;
                if (!flush) begin
                    insn_n  = mem_rdata;
                    ipc_n   = mem_addr;
                    valid_n = 1'b1;
                    fault_n = 1'b0;
                    adv_n   = 1'b1;
                end
            end else if (to) begin
                // a flush landing on the expiring cycle just abandons the fetch
                req_n   = 1'b0;
                state_n = flush ? IDLE : HOLD;
                if (!flush) begin
                    insn_n  = '0;
                    ipc_n   = mem_addr;
                    valid_n = 1'b1;
                    fault_n = 1'b1;
                end
            end else begin
                cnt_n   = cnt_inc;
                state_n = flush ? DROP : REQ;
            end
            DROP: if (mem_ack || to) begin
                req_n   = 1'b0;
                state_n = IDLE;
            end else begin
                cnt_n = cnt_inc;
            end
            HOLD: if (flush) begin
                valid_n = 1'b0;
                fault_n = 1'b0;
                state_n = IDLE;
            end else if (insn_ready) begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
